// File: rtl/logic_element_scan.sv
// logic_element_scan
//   K-input logic element whose configuration is loaded through a serial scan
//   chain. Each instance owns a CW-bit configuration shift register holding
//   the LUT mask, the combinational/registered output select and the output
//   register init value. Instances daisy-chain config_in -> config_out.
//
//   Optional feature macro: LE_FRACTURE_EN
//     Adds a c_frac config bit (CW grows by one) and the data_out_b port.
//     With c_frac=1 the LUT splits into two (K-1)-input halves sharing
//     data_in[K-2:0]: the lower half drives data_out, the upper data_out_b.
//
// Parameters
//   K                LUT input count (2..8), default 6
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   config_shift_en  shift the config chain by one bit this cycle
//   config_in        serial config bit from upstream
//   config_out       serial config bit to downstream (shreg[0])
//   config_done      high once CW bits have been shifted in since reset
//   data_in[K-1:0]   LUT select inputs
//   enable           clock enable of the output register
//   data_out         element output (gated low until config_done)
//   data_out_b       second fractured output (LE_FRACTURE_EN only)

module logic_element_scan #(
  parameter int K = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         config_shift_en,
  input  logic         config_in,
  output logic         config_out,
  output logic         config_done,
  input  logic [K-1:0] data_in,
  input  logic         enable,
`ifdef LE_FRACTURE_EN
  output logic         data_out_b,
`endif
  output logic         data_out
);

  localparam int LUT_N = 1 << K;
`ifdef LE_FRACTURE_EN
  localparam int CW = LUT_N + 3;
`else
  localparam int CW = LUT_N + 2;
`endif
  localparam int CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] CW_CNT = CNT_W'(CW);

  logic [CW-1:0]    shreg;
  logic [CW-1:0]    shreg_nxt;
  logic [CNT_W-1:0] count;
  logic             q;
  logic             lut_z;

  logic [LUT_N-1:0] c_lut;
  logic             c_comb;
  logic             c_init;

  assign c_lut  = shreg[LUT_N-1:0];
  assign c_comb = shreg[LUT_N];
  assign c_init = shreg[LUT_N+1];

  // Next value of the chain; also used so that the output register loads the
  // init bit of the configuration that will be live after this edge. That way
  // the first cycle with config_done high already shows the final c_init.
  always_comb begin
    shreg_nxt = shreg;
    if (config_shift_en) shreg_nxt = {config_in, shreg[CW-1:1]};
  end

  // ---- config chain and bit counter ----
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
      count <= '0;
    end else begin
      shreg <= shreg_nxt;
      if (config_shift_en && (count != CW_CNT))
        count <= count + CNT_W'(1);
    end
  end

  assign config_done = (count == CW_CNT);
  assign config_out  = shreg[0];

  // ---- LUT ----
`ifdef LE_FRACTURE_EN
  logic c_frac;
  logic lut_hi;
  assign c_frac = shreg[LUT_N+2];
  assign lut_hi = c_lut[{1'b1, data_in[K-2:0]}];
  always_comb begin
    lut_z = c_lut[data_in];
    if (c_frac) lut_z = c_lut[{1'b0, data_in[K-2:0]}];
  end
  // Upper half is combinational only and stays gated until fully loaded.
  assign data_out_b = config_done & c_frac & lut_hi;
`else
  assign lut_z = c_lut[data_in];
`endif

  // ---- output register ----
  always_ff @(posedge clock) begin
    if (reset)
      q <= 1'b0;
    else if (!config_done)
      q <= shreg_nxt[LUT_N+1];
    else if (enable)
      q <= lut_z;
  end

  // Partial configuration must never drive routing.
  assign data_out = config_done & (c_comb ? lut_z : q);

endmodule

// File: doc/logic_element_scan.md
# logic_element_scan

Parametrised K-input logic element with an integrated serial configuration scan chain, replacing the fixed 6-input element that takes a parallel config bus. Each instance holds its own configuration shift register: a K-LUT mask, a combinational/registered output select and a register init value. It tracks when its full configuration word has been shifted in. Instances daisy-chain through `config_in`/`config_out` inside a tile, and the tile's configuration controller drives the chain.

## Interface
Parameters:
- `K`, default 6: LUT input count; legal range 2..8.
- `CW`, derived, default 2^K+2 (2^K+3 with `LE_FRACTURE_EN`): configuration word width in bits.

Ports:
- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `config_shift_en` input 1: shift the config chain by one bit this cycle.
- `config_in` input 1: serial config bit from the upstream element.
- `config_out` output 1: serial config bit to the downstream element, equal to `shreg[0]`.
- `config_done` output 1: registered; high once CW bits have been shifted in since reset.
- `data_in` input K: LUT select inputs.
- `enable` input 1: clock enable of the output register.
- `data_out` output 1: element output.
- `data_out_b` output 1: present only with `LE_FRACTURE_EN`; second fractured LUT output.

## Operation
- Config field map, `shreg[CW-1:0]`:
  - `[2^K-1:0]` LUT mask, `c_lut`.
  - `[2^K]` `c_comb`: 1 selects the combinational output, 0 the registered output.
  - `[2^K+1]` `c_init`: value the output register holds until configuration completes.
  - `[2^K+2]` `c_frac`: only with `LE_FRACTURE_EN`.
- Shift: when `config_shift_en` is high, `shreg <= {config_in, shreg[CW-1:1]}`. The first bit shifted in lands in `shreg[0]` after CW shifts. The chain always shifts, including after `config_done`; the live config changes accordingly.
- Bit counter: width `$clog2(CW+1)`. It increments on each shift and saturates at CW. `config_done = (count == CW)`, taken from the registered count.
- LUT: `lut_z = c_lut[data_in]`, purely combinational.
- Output register `q`:
  - `reset` → 0.
  - else if `!config_done` → `c_init`.
  - else if `enable` → `lut_z`.
  - else hold.
- Output: `data_out = !config_done ? 0 : (c_comb ? lut_z : q)`. Outputs are gated low during load so that partial config never drives routing.
- Reset values:
  - `shreg` = 0, count = 0, `q` = 0.
  - `config_done` = 0, `data_out` = 0, `config_out` = 0, `data_out_b` = 0.
- Reset mid-load discards all shifted bits, and the count restarts at 0.
- Reset and `config_shift_en` in the same cycle: reset wins, and no shift occurs.
- `enable` low while `config_done` is low has no effect; `q` still tracks `c_init`.

## Timing
- Shift latency is one cycle: a bit presented on `config_in` at edge n appears on `config_out` after CW edges.
- `config_done` rises on the same edge that performs the CW-th shift, so it is visible in the following cycle.
- The combinational path `data_in` → `data_out` applies when `c_comb`=1 and has zero latency.
- The registered path applies when `c_comb`=0. `data_out` reflects the `lut_z` sampled at the last edge where `enable`=1, giving one cycle of latency.
- On the first cycle with `config_done`=1 and `c_comb`=0, `data_out` equals `c_init` until the first enabled capture.

## Configuration
- Macro: `LE_FRACTURE_EN`.
- Defined:
  - CW = 2^K+3, and port `data_out_b` exists.
  - When `c_frac`=1, the LUT splits into two (K-1)-input LUTs sharing `data_in[K-2:0]`.
  - `lut_z = c_lut[{1'b0, data_in[K-2:0]}]` (lower half).
  - `data_out_b = c_lut[{1'b1, data_in[K-2:0]}]` (upper half), combinational only.
  - `data_out_b` is gated to 0 while `!config_done`.
  - When `c_frac`=0, behaviour is identical to the undefined case, and `data_out_b` = 0.
- Undefined: CW = 2^K+2, and there is no `data_out_b` port or `c_frac` bit.

## Test plan
- K=4, CW=18.
  - Stimulus: shift in mask 16'h8000 (AND4), `c_comb`=1, `c_init`=0.
  - Required: `config_done` rises after the 18th shift.
  - Required: `data_in`=4'hF gives `data_out`=1 in the same cycle; 4'hE gives 0.
- K=4, registered mode.
  - Stimulus: mask 16'h6996 (XOR4), `c_comb`=0, `c_init`=1.
  - Required: first cycle after done, `data_out`=1.
  - Required: `data_in`=4'h1 with `enable`=1 gives `data_out`=1 one cycle later.
  - Required: `enable`=0 with `data_in`=4'h3 holds the value.
- Stimulus: assert `reset` after 10 of 18 shifts, then shift 18 fresh bits.
  - Required: `config_done` stays 0 until the 18th fresh shift.
  - Required: `config_out` replays only the fresh bits.
- Chain passthrough.
  - Stimulus: after done, shift 18 more bits.
  - Required: `config_out` emits the original 18 bits in order, first-in first.
  - Required: `config_done` stays 1.
- During load.
  - Stimulus: drive all `data_in` patterns before done.
  - Required: `data_out`=0 regardless of mask or `c_comb`.
- `LE_FRACTURE_EN`, K=4, CW=19.
  - Stimulus: `c_frac`=1, mask 16'hFF00.
  - Required: `data_out`=0 and `data_out_b`=1 for every `data_in`.
  - Required: with `c_frac`=0, `data_out_b`=0.
